// File: rtl/alu_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_ctrl_pkg
// Shared types for the sequencing ALU controller.
//   alu_op_t : 3-bit ALU operation select. Encoding 3'd7 is unused and is
//              treated as idle_alu wherever a command is accepted.
// ----------------------------------------------------------------------------
package alu_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      idle_alu = 3'd0,   // no operation, accumulator untouched
      pass_alu = 3'd1,   // c = b
      add_alu  = 3'd2,   // c = a + b
      sub_alu  = 3'd3,   // c = a - b
      mul_alu  = 3'd4,   // c = low WIDTH bits of a * b
      inc_alu  = 3'd5,   // c = a + 1
      clr_alu  = 3'd6    // c = 0
   } alu_op_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// alu_seq_ctrl
// Accumulator-based sequencer for an external combinational ALU. A command
// (operation + operand) is accepted in IDLE, applied to the accumulator in a
// single EXEC cycle, and the new accumulator value is offered in RESP until
// the consumer takes it. One command every three cycles at best.
//
// Optional feature macro: ALU_SEQ_OVF_FLAG_EN
//   defined   : res_ovf is a signed-overflow flag captured at the EXEC edge.
//   undefined : res_ovf is tied to 0 and no overflow logic exists.
//
// Parameters
//   WIDTH        operand / accumulator width in bits (default 12)
// Ports
//   clk          clock, rising edge
//   rstN         asynchronous active-low reset
//   cmd_valid    command request present
//   cmd_ready    controller can accept a command (IDLE only)
//   cmd_op       requested operation (illegal encodings -> idle_alu)
//   cmd_operand  second operand (signed)
//   alu_a        ALU operand a, always the accumulator
//   alu_b        ALU operand b, latched operand in EXEC, else 0
//   alu_sel      ALU operation, latched op in EXEC, else idle_alu
//   alu_c        combinational ALU result
//   res_valid    result available (RESP)
//   res_ready    consumer accepts result
//   res_data     accumulator value after the command
//   res_ovf      signed overflow flag of the last command
// ----------------------------------------------------------------------------
module alu_seq_ctrl
   import alu_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic                    clk,
   input  logic                    rstN,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  alu_op_t                 cmd_op,
   input  logic signed [WIDTH-1:0] cmd_operand,
   output logic signed [WIDTH-1:0] alu_a,
   output logic signed [WIDTH-1:0] alu_b,
   output alu_op_t                 alu_sel,
   input  logic signed [WIDTH-1:0] alu_c,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic signed [WIDTH-1:0] res_data,
   output logic                    res_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic signed [WIDTH-1:0] ac_reg, ac_next;
   alu_op_t                 op_reg, op_next;
   logic signed [WIDTH-1:0] operand_reg, operand_next;
   // Cleared by reset and set on the first edge afterwards, so cmd_ready
   // stays low while reset is held and until the first clock after release.
   logic                    ready_en_reg;
   alu_op_t                 op_legal;

   // Map unused encodings onto idle_alu at the point of capture so the rest
   // of the design only ever sees legal operations.
   always_comb begin
      op_legal = idle_alu;
      case (cmd_op)
         idle_alu, pass_alu, add_alu, sub_alu,
         mul_alu, inc_alu, clr_alu: op_legal = cmd_op;
         default:                   op_legal = idle_alu;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_reg    <= IDLE;
         ac_reg       <= '0;
         op_reg       <= idle_alu;
         operand_reg  <= '0;
         ready_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ac_reg       <= ac_next;
         op_reg       <= op_next;
         operand_reg  <= operand_next;
         ready_en_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next   = state_reg;
      ac_next      = ac_reg;
      op_next      = op_reg;
      operand_next = operand_reg;
      cmd_ready    = 1'b0;
      res_valid    = 1'b0;
      alu_sel      = idle_alu;
      alu_b        = '0;

      case (state_reg)
         IDLE: begin
            cmd_ready = ready_en_reg;
            if (cmd_valid && ready_en_reg) begin
               op_next      = op_legal;
               operand_next = cmd_operand;
               state_next   = EXEC;
            end
         end
         EXEC: begin
            alu_sel = op_reg;
            alu_b   = operand_reg;
            // idle_alu still produces a response, it just leaves AC alone.
            if (op_reg != idle_alu) begin
               ac_next = alu_c;
            end
            state_next = RESP;
         end
         RESP: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand a is the accumulator in every state; the response is the
   // accumulator too, which cannot change while sitting in RESP.
   assign alu_a    = ac_reg;
   assign res_data = ac_reg;

`ifdef ALU_SEQ_OVF_FLAG_EN
   localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

   logic signed [2*WIDTH-1:0] ac_ext;
   logic signed [2*WIDTH-1:0] opd_ext;
   logic signed [2*WIDTH-1:0] prod;
   logic        [WIDTH-1:0]   hi_diff;
   logic                      ovf_calc;
   logic                      ovf_reg;

   // Full-precision product: it fits in WIDTH bits only if every upper bit
   // is a copy of the result sign bit.
   assign ac_ext  = {{WIDTH{ac_reg[WIDTH-1]}}, ac_reg};
   assign opd_ext = {{WIDTH{operand_reg[WIDTH-1]}}, operand_reg};
   assign prod    = ac_ext * opd_ext;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mul_hi
      assign hi_diff[gi] = prod[WIDTH+gi] ^ prod[WIDTH-1];
   end

   always_comb begin
      ovf_calc = 1'b0;
      case (op_reg)
         add_alu: ovf_calc = (ac_reg[WIDTH-1] == operand_reg[WIDTH-1]) &&
                             (alu_c[WIDTH-1]  != ac_reg[WIDTH-1]);
         sub_alu: ovf_calc = (ac_reg[WIDTH-1] != operand_reg[WIDTH-1]) &&
                             (alu_c[WIDTH-1]  != ac_reg[WIDTH-1]);
         inc_alu: ovf_calc = (ac_reg == MAX_POS);
         mul_alu: ovf_calc = |hi_diff;
         default: ovf_calc = 1'b0;
      endcase
   end

   // Only written at the EXEC edge, so it holds steady through RESP.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ovf_reg <= 1'b0;
      end else if (state_reg == EXEC) begin
         ovf_reg <= ovf_calc;
      end
   end

   assign res_ovf = ovf_reg;
`else
   assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed bench for alu_seq_ctrl with WIDTH=12 and a behavioural ALU hooked
// to alu_a/alu_b/alu_sel/alu_c. Expected values are hand-computed constants.
// Overflow expectations follow ALU_SEQ_OVF_FLAG_EN.
// ----------------------------------------------------------------------------
module tb_alu_seq_ctrl;
   import alu_seq_ctrl_pkg::*;

   localparam int W = 12;
`ifdef ALU_SEQ_OVF_FLAG_EN
   localparam int OVF = 1;
`else
   localparam int OVF = 0;
`endif

   logic                clk;
   logic                rstN;
   logic                cmd_valid;
   logic                cmd_ready;
   alu_op_t             cmd_op;
   logic signed [W-1:0] cmd_operand;
   logic signed [W-1:0] alu_a;
   logic signed [W-1:0] alu_b;
   alu_op_t             alu_sel;
   logic signed [W-1:0] alu_c;
   logic                res_valid;
   logic                res_ready;
   logic signed [W-1:0] res_data;
   logic                res_ovf;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_ac  = 0;

   alu_seq_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rstN        (rstN),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_operand (cmd_operand),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sel     (alu_sel),
      .alu_c       (alu_c),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_ovf     (res_ovf)
   );

   // Attached ALU. For idle_alu it returns ~a so a wrongful AC write shows.
   always_comb begin
      alu_c = ~alu_a;
      case (alu_sel)
         pass_alu: alu_c = alu_b;
         add_alu:  alu_c = alu_a + alu_b;
         sub_alu:  alu_c = alu_a - alu_b;
         mul_alu:  alu_c = alu_a * alu_b;
         inc_alu:  alu_c = alu_a + 12'sd1;
         clr_alu:  alu_c = '0;
         default:  alu_c = ~alu_a;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one command from IDLE and follow it through EXEC and RESP.
   // hold = number of extra RESP cycles with res_ready low.
   task automatic do_cmd(input string tag, input alu_op_t op, input int operand,
                         input alu_op_t exp_sel, input int exp_res,
                         input int exp_ovf, input int hold);
      logic signed [W-1:0] opd;
      opd = operand[W-1:0];
      @(negedge clk);
      check({tag, ".idle_ready"}, cmd_ready, 1);
      check({tag, ".idle_sel"}, alu_sel, idle_alu);
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_operand = opd;
      res_ready   = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      // EXEC: a stray request must be ignored
      cmd_op      = clr_alu;
      cmd_operand = 12'sh555;
      check({tag, ".exec_valid"}, res_valid, 0);
      check({tag, ".exec_ready"}, cmd_ready, 0);
      check({tag, ".exec_sel"}, alu_sel, exp_sel);
      check({tag, ".exec_a"}, alu_a, exp_ac);
      check({tag, ".exec_b"}, alu_b, operand);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".resp_valid"}, res_valid, 1);
      check({tag, ".resp_data"}, res_data, exp_res);
      check({tag, ".resp_ovf"}, res_ovf, exp_ovf);
      check({tag, ".resp_sel"}, alu_sel, idle_alu);
      check({tag, ".resp_b"}, alu_b, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, ".hold_valid"}, res_valid, 1);
         check({tag, ".hold_data"}, res_data, exp_res);
         check({tag, ".hold_ovf"}, res_ovf, exp_ovf);
         check({tag, ".hold_ready"}, cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, ".done_valid"}, res_valid, 0);
      check({tag, ".done_ready"}, cmd_ready, 1);
      $display("[TB] %s op=%0d operand=%0d -> res_data=%0d res_ovf=%0b",
               tag, int'(op), operand, int'(res_data), res_ovf);
      exp_ac = exp_res;
   endtask

   initial begin
      rstN        = 1'b0;
      cmd_valid   = 1'b1;
      cmd_op      = add_alu;
      cmd_operand = 12'sd9;
      res_ready   = 1'b1;

      // In reset: outputs at their reset values, request ignored
      #23;
      check("rst.cmd_ready", cmd_ready, 0);
      check("rst.res_valid", res_valid, 0);
      check("rst.res_data", res_data, 0);
      check("rst.alu_sel", alu_sel, idle_alu);
      check("rst.alu_a", alu_a, 0);
      check("rst.alu_b", alu_b, 0);
      check("rst.res_ovf", res_ovf, 0);
      cmd_valid = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      #1;
      check("rel.before_edge_ready", cmd_ready, 0);
      @(posedge clk);
      @(negedge clk);
      check("rel.after_edge_ready", cmd_ready, 1);
      $display("[TB] reset released, cmd_ready=%0b", cmd_ready);

      // Basic sequence
      do_cmd("seq.pass10", pass_alu, 10,  pass_alu, 10, 0, 0);
      do_cmd("seq.add3",   add_alu,  3,   add_alu,  13, 0, 0);
      do_cmd("seq.sub-30", sub_alu,  -30, sub_alu,  43, 0, 0);
      do_cmd("seq.mul2",   mul_alu,  2,   mul_alu,  86, 0, 0);
      do_cmd("seq.inc",    inc_alu,  0,   inc_alu,  87, 0, 0);
      do_cmd("seq.clr",    clr_alu,  0,   clr_alu,  0,  0, 0);

      // Back-pressure
      do_cmd("bp.add5",    add_alu,  5,   add_alu,  5,  0, 4);

      // idle_alu and an illegal encoding leave AC alone
      do_cmd("idle.pass13", pass_alu, 13, pass_alu, 13, 0, 0);
      do_cmd("idle.idle",   idle_alu, 77, idle_alu, 13, 0, 0);
      do_cmd("idle.illegal", alu_op_t'(3'd7), 100, idle_alu, 13, 0, 0);

      // Wrap-around and overflow flags
      do_cmd("ovf.pass2047", pass_alu, 2047, pass_alu, 2047,  0,   0);
      do_cmd("ovf.inc",      inc_alu,  0,    inc_alu,  -2048, OVF, 0);
      do_cmd("ovf.sub1",     sub_alu,  1,    sub_alu,  2047,  OVF, 0);
      do_cmd("ovf.pass2000", pass_alu, 2000, pass_alu, 2000,  0,   0);
      do_cmd("ovf.add100",   add_alu,  100,  add_alu,  -1996, OVF, 0);
      do_cmd("ovf.pass100",  pass_alu, 100,  pass_alu, 100,   0,   0);
      do_cmd("ovf.mul100",   mul_alu,  100,  mul_alu,  1808,  OVF, 0);
      do_cmd("ovf.pass-3",   pass_alu, -3,   pass_alu, -3,    0,   0);
      do_cmd("ovf.mul5",     mul_alu,  5,    mul_alu,  -15,   0,   0);

      // Reset pulse during EXEC aborts the command
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_op      = add_alu;
      cmd_operand = 12'sd7;
      res_ready   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("abort.exec_sel", alu_sel, add_alu);
      rstN = 1'b0;
      #1;
      check("abort.rst_ready", cmd_ready, 0);
      check("abort.rst_data", res_data, 0);
      check("abort.rst_sel", alu_sel, idle_alu);
      check("abort.rst_b", alu_b, 0);
      #2;
      rstN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("abort.no_valid", res_valid, 0);
         check("abort.ac_zero", res_data, 0);
         check("abort.ready", cmd_ready, 1);
      end
      $display("[TB] abort: res_valid=%0b res_data=%0d cmd_ready=%0b",
               res_valid, int'(res_data), cmd_ready);
      exp_ac = 0;
      do_cmd("abort.add4", add_alu, 4, add_alu, 4, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
